// File: rtl/calc_pkg.sv
// Shared types and constants for the UART ASCII calculator sequencer.
// CALC_CRLF_EN (in calc_seq_ctrl) appends CR/LF after each result byte.
package calc_pkg;

   localparam int LAT_W = 4;
   localparam int TMO_W = 24;

   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_DIG   = 8'h30;
   localparam logic [7:0] ASCII_HI    = 8'h50;

   typedef enum logic [2:0] {
      GET_A,
      GET_B,
      GET_OP,
      WAIT,
      SEND,
      SEND_CR,
      SEND_LF
   } state_e;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Byte handshake, datapath and status bundle of the calculator sequencer.
// master = sequencer side, slave = UART / datapath / board side.
interface calc_seq_ctrl_if;

   logic [7:0] rx_data;
   logic       rx_data_rdy;
   logic [7:0] tx_data;
   logic       tx_data_rdy;
   logic       tx_busy;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic       alu_sub;
   logic [4:0] alu_res;
   logic [4:0] leds;
   logic       err;

   modport master (
      input  rx_data, rx_data_rdy, tx_busy, alu_res,
      output tx_data, tx_data_rdy, alu_a, alu_b, alu_sub, leds, err
   );

   modport slave (
      output rx_data, rx_data_rdy, tx_busy, alu_res,
      input  tx_data, tx_data_rdy, alu_a, alu_b, alu_sub, leds, err
   );

endinterface

// File: rtl/calc_ascii_codec.sv
// ASCII byte -> operand nibble decode and 5-bit result -> ASCII encode.
module calc_ascii_codec
   import calc_pkg::*;
(
   input  logic [7:0] asc_i,
   output logic [3:0] nib_o,
   input  logic [4:0] res_i,
   output logic [7:0] asc_o
);

   logic hex_lo;
   logic hex_row;

   assign hex_lo  = (asc_i[3:0] >= 4'h1) && (asc_i[3:0] <= 4'h6);
   assign hex_row = (asc_i[7:4] == 4'h4) || (asc_i[7:4] == 4'h6);

   always_comb begin
      nib_o = 4'h0;
      unique case (1'b1)
         (asc_i[7:4] == 4'h3): nib_o = asc_i[3:0];
         (asc_i[7:4] == 4'h5): nib_o = asc_i[3:0];
         (hex_row && hex_lo):  nib_o = asc_i[3:0] + 4'h9;
         default:              nib_o = 4'h0;
      endcase
   end

   assign asc_o = (res_i[4] ? ASCII_HI : ASCII_DIG) + {4'h0, res_i[3:0]};

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: A, B, operator bytes in; one ASCII result byte out.
// Define CALC_CRLF_EN to follow each result with CR and LF.
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int ALU_LAT     = 1,
   parameter int TIMEOUT_CYC = 12000000
) (
   input  logic           clk12m,
   input  logic           rst_n,
   calc_seq_ctrl_if.master bus
);

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);

`ifdef CALC_CRLF_EN
   localparam state_e AFTER_RES = SEND_CR;
`else
   localparam state_e AFTER_RES = GET_A;
`endif

   state_e           state_q, state_d;
   logic [3:0]       alu_a_q, alu_a_d;
   logic [3:0]       alu_b_q, alu_b_d;
   logic             alu_sub_q, alu_sub_d;
   logic [4:0]       leds_q, leds_d;
   logic [4:0]       res_q, res_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_rdy_q, tx_rdy_d;
   logic             err_q, err_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic [3:0] rx_nib;
   logic [7:0] res_asc;
   logic       rx;
   logic       op_add;
   logic       op_sub;
   logic       tx_go;
   logic       tmo_hit;

   calc_ascii_codec u_codec (
      .asc_i (bus.rx_data),
      .nib_o (rx_nib),
      .res_i (res_q),
      .asc_o (res_asc)
   );

   assign rx     = bus.rx_data_rdy;
   assign op_add = (bus.rx_data == ASCII_PLUS);
   assign op_sub = (bus.rx_data == ASCII_MINUS);
   // A strobe just issued counts as busy so strobes never abut
   assign tx_go  = !bus.tx_busy && !tx_rdy_q;
   assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST) &&
                    ((state_q == GET_B) || (state_q == GET_OP));

   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sub_d = alu_sub_q;
      leds_d    = leds_q;
      res_d     = res_q;
      tx_data_d = tx_data_q;
      tx_rdy_d  = 1'b0;
      err_d     = 1'b0;
      lat_cnt_d = lat_cnt_q;
      tmo_cnt_d = tmo_cnt_q;

      // Timeout wins over B/op capture; a coincident byte restarts as A
      if (tmo_hit) begin
         err_d     = 1'b1;
         tmo_cnt_d = '0;
         state_d   = GET_A;
         if (rx) begin
            alu_a_d = rx_nib;
            state_d = GET_B;
         end
      end else begin
         unique case (state_q)
            GET_A: begin
               if (rx) begin
                  alu_a_d   = rx_nib;
                  tmo_cnt_d = '0;
                  state_d   = GET_B;
               end
            end
            GET_B: begin
               if (rx) begin
                  alu_b_d   = rx_nib;
                  tmo_cnt_d = '0;
                  state_d   = GET_OP;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
            GET_OP: begin
               if (rx) begin
                  tmo_cnt_d = '0;
                  if (op_add || op_sub) begin
                     alu_sub_d = op_sub;
                     lat_cnt_d = '0;
                     state_d   = WAIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = GET_A;
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
            WAIT: begin
               err_d = rx;
               if (lat_cnt_q == LAT_LAST) begin
                  leds_d  = bus.alu_res;
                  res_d   = bus.alu_res;
                  state_d = SEND;
               end else begin
                  lat_cnt_d = lat_cnt_q + LAT_W'(1);
               end
            end
            SEND: begin
               err_d = rx;
               if (tx_go) begin
                  tx_data_d = res_asc;
                  tx_rdy_d  = 1'b1;
                  state_d   = AFTER_RES;
               end
            end
`ifdef CALC_CRLF_EN
            SEND_CR: begin
               err_d = rx;
               if (tx_go) begin
                  tx_data_d = ASCII_CR;
                  tx_rdy_d  = 1'b1;
                  state_d   = SEND_LF;
               end
            end
            SEND_LF: begin
               err_d = rx;
               if (tx_go) begin
                  tx_data_d = ASCII_LF;
                  tx_rdy_d  = 1'b1;
                  state_d   = GET_A;
               end
            end
`endif
            default: state_d = GET_A;
         endcase
      end
   end

   always_ff @(posedge clk12m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= GET_A;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sub_q <= 1'b0;
         leds_q    <= '0;
         res_q     <= '0;
         tx_data_q <= '0;
         tx_rdy_q  <= 1'b0;
         err_q     <= 1'b0;
         lat_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sub_q <= alu_sub_d;
         leds_q    <= leds_d;
         res_q     <= res_d;
         tx_data_q <= tx_data_d;
         tx_rdy_q  <= tx_rdy_d;
         err_q     <= err_d;
         lat_cnt_q <= lat_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.tx_data_rdy = tx_rdy_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_sub     = alu_sub_q;
   assign bus.leds        = leds_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with an add/sub datapath model.
module tb_calc_seq_ctrl;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [3:0] ea;
      logic [3:0] eb;
      logic       esub;
      logic [4:0] eleds;
      logic       tx_ok;
      logic [7:0] etx;
      int         eerr;
   } vec_t;

`ifdef CALC_CRLF_EN
   localparam int NTX = 3;
`else
   localparam int NTX = 1;
`endif

   logic clk12m = 1'b0;
   logic rst_n  = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   err_cnt = 0;
   logic [7:0] txq[$];
   int         txc[$];

   logic [7:0] ref_in;
   logic [3:0] ref_nib;
   logic [4:0] ref_res;
   logic [7:0] ref_asc;

   calc_seq_ctrl_if bus ();

   calc_seq_ctrl #(
      .ALU_LAT     (1),
      .TIMEOUT_CYC (20)
   ) dut (
      .clk12m (clk12m),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   calc_ascii_codec u_ref (
      .asc_i (ref_in),
      .nib_o (ref_nib),
      .res_i (ref_res),
      .asc_o (ref_asc)
   );

   always #5 clk12m = ~clk12m;

   always @(posedge clk12m) cyc <= cyc + 1;

   // External add/sub datapath, combinational
   assign bus.alu_res = bus.alu_sub ?
      ({1'b0, bus.alu_a} - {1'b0, bus.alu_b}) :
      ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});

   always @(negedge clk12m) begin
      if (bus.tx_data_rdy) begin
         txq.push_back(bus.tx_data);
         txc.push_back(cyc);
      end
      if (bus.err) err_cnt = err_cnt + 1;
   end

   function automatic void chk(string name, logic [31:0] got,
                               logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk12m);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk12m);
      bus.rx_data     = b;
      bus.rx_data_rdy = 1'b1;
      @(negedge clk12m);
      bus.rx_data_rdy = 1'b0;
   endtask

   task automatic send3(input vec_t v, output int op_c);
      send_byte(v.a);
      send_byte(v.b);
      send_byte(v.op);
      op_c = cyc;
   endtask

   task automatic check_regs(input vec_t v, input int op_c);
      wait_cyc(op_c + 1);
      chk("alu_a", 32'(bus.alu_a), 32'(v.ea));
      chk("alu_b", 32'(bus.alu_b), 32'(v.eb));
      chk("alu_sub", 32'(bus.alu_sub), 32'(v.esub));
      chk("leds", 32'(bus.leds), 32'(v.eleds));
   endtask

   task automatic check_tx(input vec_t v, input int t0, input int err0);
      wait_cyc(t0 + 8);
      chk("err_pulses", 32'(err_cnt - err0), 32'(v.eerr));
      if (v.tx_ok) begin
         chk("tx_count", 32'(txq.size()), 32'(NTX));
         if (txq.size() > 0) begin
            chk("tx_data", 32'(txq[0]), 32'(v.etx));
            chk("tx_time", 32'(txc[0]), 32'(t0));
         end
`ifdef CALC_CRLF_EN
         if (txq.size() > 2) begin
            chk("tx_cr", 32'(txq[1]), 32'h0D);
            chk("tx_lf", 32'(txq[2]), 32'h0A);
            chk("tx_lf_time", 32'(txc[2]), 32'(t0 + 4));
         end
`endif
      end else begin
         chk("tx_none", 32'(txq.size()), 32'd0);
      end
      txq.delete();
      txc.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int op_c;
      int err0;
      err0 = err_cnt;
      send3(v, op_c);
      check_regs(v, op_c);
      check_tx(v, op_c + 2, err0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      chk({tag, "_tx_rdy"}, 32'(bus.tx_data_rdy), 32'd0);
      chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
      chk({tag, "_alu_sub"}, 32'(bus.alu_sub), 32'd0);
      chk({tag, "_leds"}, 32'(bus.leds), 32'd0);
      chk({tag, "_err"}, 32'(bus.err), 32'd0);
   endtask

   vec_t tv[9];
   vec_t v;
   int   op_c;
   int   err0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      tv[0] = '{8'h30, 8'h34, 8'h2B, 4'h0, 4'h4, 1'b0, 5'h04, 1'b1, 8'h34, 0};
      tv[1] = '{8'h35, 8'h32, 8'h2D, 4'h5, 4'h2, 1'b1, 5'h03, 1'b1, 8'h33, 0};
      tv[2] = '{8'h32, 8'h33, 8'h2D, 4'h2, 4'h3, 1'b1, 5'h1F, 1'b1, 8'h5F, 0};
      tv[3] = '{8'h31, 8'h32, 8'h2A, 4'h1, 4'h2, 1'b1, 5'h1F, 1'b0, 8'h00, 1};
      tv[4] = '{8'h31, 8'h32, 8'h2B, 4'h1, 4'h2, 1'b0, 5'h03, 1'b1, 8'h33, 0};
      tv[5] = '{8'h41, 8'h66, 8'h2B, 4'hA, 4'hF, 1'b0, 5'h19, 1'b1, 8'h59, 0};
      tv[6] = '{8'h50, 8'h5F, 8'h2D, 4'h0, 4'hF, 1'b1, 5'h11, 1'b1, 8'h51, 0};
      tv[7] = '{8'h7A, 8'h39, 8'h2B, 4'h0, 4'h9, 1'b0, 5'h09, 1'b1, 8'h39, 0};
      tv[8] = '{8'h3F, 8'h47, 8'h2B, 4'hF, 4'h0, 1'b0, 5'h0F, 1'b1, 8'h3F, 0};

      bus.rx_data     = 8'h00;
      bus.rx_data_rdy = 1'b0;
      bus.tx_busy     = 1'b0;
      ref_in          = 8'h63;
      ref_res         = 5'h04;
      repeat (3) @(negedge clk12m);
      #1;
      check_zero("reset");
      chk("codec_dec_c", 32'(ref_nib), 32'hC);
      chk("codec_enc_04", 32'(ref_asc), 32'h34);
      ref_res = 5'h1F;
      #1;
      chk("codec_enc_1f", 32'(ref_asc), 32'h5F);
      @(negedge clk12m);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(tv[i]);

      // Transmitter busy for 10 cycles after the LED update
      v = '{8'h39, 8'h39, 8'h2B, 4'h9, 4'h9, 1'b0, 5'h12, 1'b1, 8'h52, 0};
      err0 = err_cnt;
      bus.tx_busy = 1'b1;
      send3(v, op_c);
      check_regs(v, op_c);
      wait_cyc(op_c + 11);
      chk("busy_no_tx", 32'(txq.size()), 32'd0);
      bus.tx_busy = 1'b0;
      check_tx(v, op_c + 12, err0);

      // Idle timeout after operand A
      err0 = err_cnt;
      send_byte(8'h37);
      repeat (25) @(negedge clk12m);
      #1;
      chk("timeout_err", 32'(err_cnt - err0), 32'd1);
      chk("timeout_no_tx", 32'(txq.size()), 32'd0);
      run_vec(tv[4]);

      // Byte arriving on the timeout edge becomes the new operand A
      v = '{8'h33, 8'h34, 8'h2B, 4'h3, 4'h4, 1'b0, 5'h07, 1'b1, 8'h37, 1};
      err0 = err_cnt;
      send_byte(8'h37);
      repeat (18) @(negedge clk12m);
      send_byte(8'h33);
      send_byte(8'h34);
      send_byte(8'h2B);
      op_c = cyc;
      check_regs(v, op_c);
      check_tx(v, op_c + 2, err0);

      // Byte during WAIT is dropped with err, result unaffected
      v = '{8'h33, 8'h33, 8'h2B, 4'h3, 4'h3, 1'b0, 5'h06, 1'b1, 8'h36, 1};
      err0 = err_cnt;
      send_byte(8'h33);
      send_byte(8'h33);
      @(negedge clk12m);
      bus.rx_data     = 8'h2B;
      bus.rx_data_rdy = 1'b1;
      @(negedge clk12m);
      op_c = cyc;
      bus.rx_data     = 8'h39;
      @(negedge clk12m);
      bus.rx_data_rdy = 1'b0;
      check_regs(v, op_c);
      check_tx(v, op_c + 2, err0);

      // Reset in GET_OP discards the partial transaction
      send_byte(8'h33);
      send_byte(8'h34);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) @(negedge clk12m);
      rst_n = 1'b1;
      repeat (4) @(negedge clk12m);
      #1;
      chk("midreset_no_tx", 32'(txq.size()), 32'd0);
      v = '{8'h36, 8'h31, 8'h2D, 4'h6, 4'h1, 1'b1, 5'h05, 1'b1, 8'h35, 0};
      run_vec(v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
